// File: rtl/sad_buf_fill_ctrl.sv
// SAD window/frame buffer refill sequencer: streams words from data memory into
// one buffer at a time and keeps the per-buffer valid flags for decode hazards.
module sad_buf_fill_ctrl #(
    parameter  int NUM_BUF = 4,
    parameter  int DEPTH   = 16,
    parameter  int ADDR_W  = 32,
    localparam int IDX_W   = $clog2(NUM_BUF),
    localparam int LEN_W   = $clog2(DEPTH + 1)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    // Command handshake: a command transfers on a cycle with cmd_valid && cmd_ready;
    // the source holds cmd_valid and its payload stable until that cycle.
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [IDX_W-1:0]  cmd_buf,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              buf_we,
    output logic [IDX_W-1:0]  buf_sel,
    output logic [LEN_W-1:0]  buf_waddr,
    output logic [31:0]       buf_wdata,
    input  logic [NUM_BUF-1:0] buf_consume,
    output logic [NUM_BUF-1:0] buf_valid,
    output logic              all_buf_flags,
    output logic              busy,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [IDX_W-1:0]    r_buf;
    logic [ADDR_W-1:0]   r_base;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_count;

    logic                r_we;
    logic [IDX_W-1:0]    r_sel;
    logic [LEN_W-1:0]    r_waddr;
    logic [31:0]         r_wdata;

    logic [NUM_BUF-1:0]  r_valid;
    logic                r_all;

    logic [LEN_W-1:0]    w_len_clip;
    logic                w_accept;
    logic                w_wr_fire;
    logic                w_done;
    logic                w_last;
    logic [ADDR_W-1:0]   w_word_addr;
    logic [NUM_BUF-1:0]  w_valid_next;
    logic                w_unused;

    // Byte-offset bits of the base address never reach the memory port.
    assign w_unused    = ^cmd_addr[1:0];

    assign w_len_clip  = (cmd_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cmd_len;
    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    assign w_wr_fire   = (r_state == S_WAIT) && mem_rvalid;
    assign w_done      = (r_state == S_DONE);
    assign w_last      = (r_count == r_len - LEN_W'(1));
    assign w_word_addr = r_base + (ADDR_W'(r_count) << 2);

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_next_state = (w_len_clip == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_gnt) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_next_state = w_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        mem_req   = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
            end
            S_ISSUE: mem_req = 1'b1;
            default: mem_req = 1'b0;
        endcase
    end

    assign mem_addr = mem_req ? w_word_addr : '0;

    // Command latch and word counter
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_buf   <= '0;
            r_base  <= '0;
            r_len   <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_buf   <= cmd_buf;
            r_base  <= {cmd_addr[ADDR_W-1:2], 2'b00};
            r_len   <= w_len_clip;
            r_count <= '0;
        end else if (w_wr_fire) begin
            r_count <= r_count + LEN_W'(1);
        end
    end

    // Buffer write port: one registered strobe per returned word
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_wr_fire;
            if (w_wr_fire) begin
                r_sel   <= r_buf;
                r_waddr <= r_count;
                r_wdata <= mem_rdata;
            end
        end
    end

    // A DONE set is applied after the consume clear so it wins on the same bit.
    always_comb begin
        w_valid_next = r_valid & ~buf_consume;
        if (w_accept) begin
            w_valid_next[cmd_buf] = 1'b0;
        end
        if (w_done) begin
            w_valid_next[r_buf] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_valid <= '0;
            r_all   <= 1'b0;
        end else begin
            r_valid <= w_valid_next;
            r_all   <= &w_valid_next;
        end
    end

    assign buf_we        = r_we;
    assign buf_sel       = r_sel;
    assign buf_waddr     = r_waddr;
    assign buf_wdata     = r_wdata;
    assign buf_valid     = r_valid;
    assign all_buf_flags = r_all;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_sad_buf_fill_ctrl.sv
// Bench for sad_buf_fill_ctrl: directed fills against a memory responder, with a
// queue-based model of expected reads, writes and valid flags checked every cycle.
module tb_sad_buf_fill_ctrl;

    localparam int NUM_BUF = 4;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 32;
    localparam int IDX_W   = 2;
    localparam int LEN_W   = 5;

    // ---------------- clock / reset ----------------
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [IDX_W-1:0]   cmd_buf;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [LEN_W-1:0]   cmd_len;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_gnt;
    logic               mem_rvalid;
    logic [31:0]        mem_rdata;
    logic               buf_we;
    logic [IDX_W-1:0]   buf_sel;
    logic [LEN_W-1:0]   buf_waddr;
    logic [31:0]        buf_wdata;
    logic [NUM_BUF-1:0] buf_consume;
    logic [NUM_BUF-1:0] buf_valid;
    logic               all_buf_flags;
    logic               busy;
    logic [1:0]         dbg_state;

    sad_buf_fill_ctrl #(.NUM_BUF(NUM_BUF), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_buf(cmd_buf),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .buf_we(buf_we), .buf_sel(buf_sel), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .buf_consume(buf_consume), .buf_valid(buf_valid),
        .all_buf_flags(all_buf_flags), .busy(busy), .o_dbg_state(dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1111};
    endfunction

    // ---------------- memory responder ----------------
    int gnt_delay = 0;
    int rv_delay  = 0;

    initial begin
        int gcnt;
        int rcnt;
        bit rpend;
        logic [31:0] rd;
        gcnt = 0; rcnt = 0; rpend = 0; rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge Clk); #1;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (rpend) begin
                if (rcnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = rd;
                    rpend = 0;
                end else begin
                    rcnt--;
                end
            end else if (mem_req) begin
                if (gcnt >= gnt_delay) begin
                    mem_gnt = 1'b1;
                    gcnt = 0;
                    rpend = 1;
                    rcnt = rv_delay;
                    rd = mem_word(mem_addr);
                end else begin
                    gcnt++;
                end
            end
        end
    end

    // ---------------- model + scoreboard ----------------
    logic [39:0] exp_q[$];          // {last, sel, waddr, data}
    logic [31:0] exp_aq[$];
    logic [31:0] grant_log[$];
    int          we_cnt = 0;
    logic [4:0]  last_waddr = '0;
    logic [1:0]  last_sel = '0;
    bit          cmp_en = 0;
    bit          m_busy = 0;
    logic [3:0]  m_valid = '0;
    logic [1:0]  m_buf = '0;
    bit          m_outstanding = 0;
    bit          m_we_exp = 0;
    bit          m_len0_pend = 0;

    initial begin
        bit          prev_req_wait;
        logic [31:0] prev_addr;
        bit          done_now;
        logic [39:0] e;
        logic [3:0]  nv;
        logic [31:0] base;
        logic [31:0] a;
        int          len;
        prev_req_wait = 0;
        prev_addr = '0;
        forever begin
            @(negedge Clk);
            if (cmp_en) begin
                done_now = 0;
                chk("cmd_ready", cmd_ready, !m_busy);
                chk("busy", busy, m_busy);
                chk("buf_valid", buf_valid, m_valid);
                chk("all_buf_flags", all_buf_flags, &m_valid);
                chk("buf_we", buf_we, m_we_exp);
                if (buf_we) begin
                    we_cnt++;
                    last_waddr = buf_waddr;
                    last_sel = buf_sel;
                    if (exp_q.size() == 0) begin
                        fail_now("buf_we_pending_word");
                    end else begin
                        e = exp_q.pop_front();
                        chk("buf_sel", buf_sel, e[38:37]);
                        chk("buf_waddr", buf_waddr, e[36:32]);
                        chk("buf_wdata", buf_wdata, e[31:0]);
                        if (e[39]) done_now = 1;
                    end
                end
                if (m_len0_pend) begin
                    done_now = 1;
                    m_len0_pend = 0;
                end
                if (!m_busy || m_outstanding) chk("mem_req_low", mem_req, 1'b0);
                if (mem_req && prev_req_wait) chk("mem_addr_hold", mem_addr, prev_addr);
                if (mem_req && mem_gnt) begin
                    grant_log.push_back(mem_addr);
                    if (exp_aq.size() == 0) fail_now("mem_req_pending_word");
                    else chk("mem_addr", mem_addr, exp_aq.pop_front());
                    m_outstanding = 1;
                end

                // next-cycle expectations
                m_we_exp = 0;
                if (mem_rvalid && m_outstanding && !(mem_req && mem_gnt)) begin
                    m_we_exp = 1;
                    m_outstanding = 0;
                end
                nv = m_valid & ~buf_consume;
                if (m_busy && done_now) begin
                    nv[m_buf] = 1'b1;
                    m_busy = 0;
                end else if (!m_busy && cmd_valid) begin
                    len = (cmd_len > DEPTH) ? DEPTH : int'(cmd_len);
                    base = {cmd_addr[31:2], 2'b00};
                    nv[cmd_buf] = 1'b0;
                    m_busy = 1;
                    m_buf = cmd_buf;
                    for (int i = 0; i < len; i++) begin
                        a = base + 32'(4 * i);
                        exp_aq.push_back(a);
                        exp_q.push_back({(i == len - 1), cmd_buf, 5'(i), mem_word(a)});
                    end
                    if (len == 0) m_len0_pend = 1;
                end
                m_valid = nv;
                prev_req_wait = mem_req && !mem_gnt;
                prev_addr = mem_addr;
                if (!Reset_n) begin
                    m_busy = 0;
                    m_valid = '0;
                    m_outstanding = 0;
                    m_we_exp = 0;
                    m_len0_pend = 0;
                    prev_req_wait = 0;
                    exp_q.delete();
                    exp_aq.delete();
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cyc();
        @(posedge Clk); #1;
    endtask

    task automatic send_cmd(input int b, input logic [31:0] a, input int l, output int acc);
        next_cyc();
        cmd_valid = 1'b1;
        cmd_buf = IDX_W'(b);
        cmd_addr = a;
        cmd_len = LEN_W'(l);
        acc = -1;
        for (int n = 0; n < 300; n++) begin
            #1;
            if (cmd_ready === 1'b1) begin
                acc = cyc;
                break;
            end
            next_cyc();
        end
        if (acc < 0) fail_now("cmd_accept");
        next_cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input int b, input int acc, output int first);
        first = -1;
        for (int n = 0; n < 300; n++) begin
            #1;
            if (buf_valid[b] === 1'b1) begin
                first = cyc - acc;
                break;
            end
            next_cyc();
        end
        if (first < 0) fail_now("buf_valid_rise");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int n = 0; n < 2000; n++) begin
            @(posedge Clk); #2;
            if (!m_busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) fail_now("fill_complete");
    endtask

    task automatic clear_logs();
        grant_log.delete();
        we_cnt = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc;
        int first;
        logic [31:0] t1_addr [4];
        t1_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};

        cmd_valid = 1'b0; cmd_buf = '0; cmd_addr = '0; cmd_len = '0; buf_consume = '0;
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        cmp_en = 1;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_buf_we", buf_we, 1'b0);
        chk("rst_buf_valid", buf_valid, 4'b0000);
        chk("rst_all_flags", all_buf_flags, 1'b0);
        chk("rst_buf_wdata", buf_wdata, 32'h0);

        // basic fill of buffer 2
        clear_logs();
        send_cmd(2, 32'h100, 4, acc);
        wait_valid(2, acc, first);
        chk("t1_valid_latency", first, 10);
        chk("t1_buf_valid", buf_valid, 4'b0100);
        chk("t1_grants", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("t1_mem_addr_seq", grant_log[i], t1_addr[i]);
        chk("t1_writes", we_cnt, 4);
        chk("t1_last_waddr", last_waddr, 5'd3);
        chk("t1_sel", last_sel, 2'd2);
        wait_idle();

        // fill the rest; flags complete only after the fourth fill
        send_cmd(0, 32'h200, 2, acc);
        wait_idle();
        chk("t2_all_after_b0", all_buf_flags, 1'b0);
        send_cmd(1, 32'h240, 2, acc);
        wait_idle();
        chk("t2_all_after_b1", all_buf_flags, 1'b0);
        send_cmd(3, 32'h280, 2, acc);
        wait_idle();
        chk("t2_all_after_b3", all_buf_flags, 1'b1);
        chk("t2_valid_full", buf_valid, 4'b1111);
        next_cyc();
        buf_consume = 4'b0001;
        #1;
        chk("t2_all_during_consume", all_buf_flags, 1'b1);
        next_cyc();
        buf_consume = 4'b0000;
        #1;
        chk("t2_all_after_consume", all_buf_flags, 1'b0);
        chk("t2_valid_after_consume", buf_valid, 4'b1110);

        // slow grant and slow read data
        gnt_delay = 5;
        rv_delay = 3;
        clear_logs();
        send_cmd(0, 32'h400, 2, acc);
        wait_valid(0, acc, first);
        chk("t3_valid_latency", first, 22);
        chk("t3_grants", grant_log.size(), 2);
        chk("t3_addr0", grant_log[0], 32'h400);
        chk("t3_addr1", grant_log[1], 32'h404);
        chk("t3_writes", we_cnt, 2);
        wait_idle();
        gnt_delay = 0;
        rv_delay = 0;

        // zero length
        clear_logs();
        send_cmd(3, 32'h500, 0, acc);
        wait_valid(3, acc, first);
        chk("t4_len0_latency", first, 2);
        chk("t4_len0_grants", grant_log.size(), 0);
        chk("t4_len0_writes", we_cnt, 0);
        wait_idle();

        // over-long command is clipped to DEPTH
        clear_logs();
        send_cmd(0, 32'h600, 31, acc);
        wait_idle();
        chk("t4_clip_grants", grant_log.size(), 16);
        chk("t4_clip_writes", we_cnt, 16);
        chk("t4_clip_last_waddr", last_waddr, 5'd15);
        chk("t4_clip_last_addr", grant_log[15], 32'h63C);

        // unaligned base
        clear_logs();
        send_cmd(0, 32'h103, 1, acc);
        wait_idle();
        chk("t4_unaligned_grants", grant_log.size(), 1);
        chk("t4_unaligned_addr", grant_log[0], 32'h100);

        // address wrap
        clear_logs();
        send_cmd(0, 32'hFFFF_FFF8, 4, acc);
        wait_idle();
        chk("t4_wrap_addr1", grant_log[1], 32'hFFFF_FFFC);
        chk("t4_wrap_addr2", grant_log[2], 32'h0000_0000);
        chk("t4_wrap_addr3", grant_log[3], 32'h0000_0004);

        // refill a valid buffer; consume in DONE loses to the set
        send_cmd(1, 32'h300, 3, acc);
        #1;
        chk("t5_cleared_at_accept", buf_valid[1], 1'b0);
        while (cyc < acc + 7) next_cyc();
        buf_consume = 4'b0010;
        #1;
        chk("t5_final_we_in_done", buf_we, 1'b1);
        chk("t5_final_waddr", buf_waddr, 5'd2);
        next_cyc();
        buf_consume = 4'b0000;
        #1;
        chk("t5_set_wins", buf_valid[1], 1'b1);
        wait_idle();

        // reset during WAIT followed by a stray read return
        rv_delay = 4;
        send_cmd(2, 32'h500, 3, acc);
        while (cyc < acc + 3) next_cyc();
        Reset_n = 1'b0;
        next_cyc();
        Reset_n = 1'b1;
        clear_logs();
        #1;
        chk("t6_mem_req", mem_req, 1'b0);
        chk("t6_cmd_ready", cmd_ready, 1'b1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_buf_valid", buf_valid, 4'b0000);
        chk("t6_all_flags", all_buf_flags, 1'b0);
        chk("t6_buf_we", buf_we, 1'b0);
        chk("t6_mem_addr", mem_addr, 32'h0);
        repeat (8) next_cyc();
        chk("t6_no_stray_write", we_cnt, 0);
        rv_delay = 0;
        clear_logs();
        send_cmd(2, 32'h600, 2, acc);
        wait_valid(2, acc, first);
        chk("t6_refill_latency", first, 6);
        chk("t6_refill_writes", we_cnt, 2);
        chk("t6_refill_addr0", grant_log[0], 32'h600);
        wait_idle();

        repeat (2) next_cyc();
        chk("end_writes_drained", exp_q.size(), 0);
        chk("end_reads_drained", exp_aq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
